// File: rtl/conv_mac_engine_if.sv
// Handshake bundle for conv_mac_engine: input beat stream (data/kernel vectors)
// and accumulated-result stream. The engine connects to the slave modport.
interface conv_mac_engine_if #(
   parameter int DATA_W  = 8,
   parameter int LEN     = 8,
   parameter int GUARD_W = 8,
   parameter int BEAT_W  = 8
);
   localparam int RES_W = 2 * DATA_W + $clog2(LEN) + GUARD_W;

   logic [LEN*DATA_W-1:0] data;
   logic [LEN*DATA_W-1:0] kernel;
   logic                  in_last;
   logic                  in_valid;
   logic                  in_ready;
   logic [RES_W-1:0]      result;
   logic [BEAT_W-1:0]     result_beats;
   logic                  result_sat;
   logic                  out_valid;
   logic                  out_ready;

   modport master (
      output data, kernel, in_last, in_valid, out_ready,
      input  in_ready, result, result_beats, result_sat, out_valid
   );

   modport slave (
      input  data, kernel, in_last, in_valid, out_ready,
      output in_ready, result, result_beats, result_sat, out_valid
   );
endinterface

// File: rtl/conv_mac_engine.sv
// Three-stage LEN-lane multiply / adder-tree / packet accumulator engine.
// Define CONV_MAC_SATURATE_EN to clamp accumulator overflow and report it on result_sat.
module conv_mac_engine #(
   parameter int DATA_W  = 8,
   parameter int LEN     = 8,
   parameter int SIGNED  = 0,
   parameter int GUARD_W = 8,
   parameter int BEAT_W  = 8
) (
   input  logic             clk,
   input  logic             rst,
   conv_mac_engine_if.slave bus
);
   localparam int PROD_W = 2 * DATA_W;
   localparam int RES_W  = PROD_W + $clog2(LEN) + GUARD_W;
   localparam int EXT_W  = RES_W - PROD_W;
   localparam logic [BEAT_W-1:0] BEAT_MAX = '1;
   localparam logic [BEAT_W-1:0] BEAT_ONE = BEAT_W'(1);

   logic                en;
   logic [PROD_W-1:0]   prod_next   [LEN];
   logic [PROD_W-1:0]   s1_prod_reg [LEN];
   logic                s1_valid_reg;
   logic                s1_last_reg;
   logic [RES_W-1:0]    node        [2*LEN-1];
   logic [RES_W-1:0]    tree_sum;
   logic [RES_W-1:0]    s2_sum_reg;
   logic                s2_valid_reg;
   logic                s2_last_reg;
   logic [RES_W-1:0]    acc_reg;
   logic [RES_W-1:0]    acc_next;
   logic [BEAT_W-1:0]   beat_cnt_reg;
   logic [BEAT_W-1:0]   beat_next;
   logic [RES_W-1:0]    result_reg;
   logic [BEAT_W-1:0]   result_beats_reg;
   logic                out_valid_reg;

   // The whole pipeline stalls only while a finished result waits for its consumer.
   assign en           = !out_valid_reg || bus.out_ready;
   assign bus.in_ready = en;

   genvar gi;
   generate
      for (gi = 0; gi < LEN; gi++) begin : g_lane
         logic [DATA_W-1:0] d_lane;
         logic [DATA_W-1:0] k_lane;
         logic [PROD_W-1:0] d_ext;
         logic [PROD_W-1:0] k_ext;

         assign d_lane = bus.data[gi*DATA_W +: DATA_W];
         assign k_lane = bus.kernel[gi*DATA_W +: DATA_W];

         if (SIGNED != 0) begin : g_signed
            assign d_ext = {{DATA_W{d_lane[DATA_W-1]}}, d_lane};
            assign k_ext = {{DATA_W{k_lane[DATA_W-1]}}, k_lane};
         end else begin : g_unsigned
            assign d_ext = {{DATA_W{1'b0}}, d_lane};
            assign k_ext = {{DATA_W{1'b0}}, k_lane};
         end

         // Low 2*DATA_W bits of the extended product are exact in both modes.
         assign prod_next[gi] = d_ext * k_ext;
      end
   endgenerate

   function automatic logic [RES_W-1:0] extend(input logic [PROD_W-1:0] p);
      if (SIGNED != 0) begin
         return {{EXT_W{p[PROD_W-1]}}, p};
      end
      return {{EXT_W{1'b0}}, p};
   endfunction

   // Binary heap adder tree: leaves at LEN-1..2*LEN-2, root at node 0.
   always_comb begin
      for (int i = 0; i < 2 * LEN - 1; i++) begin
         node[i] = '0;
      end
      for (int i = 0; i < LEN; i++) begin
         node[LEN-1+i] = extend(s1_prod_reg[i]);
      end
      for (int i = LEN - 2; i >= 0; i--) begin
         node[i] = node[2*i+1] + node[2*i+2];
      end
   end

   assign tree_sum  = node[0];
   assign beat_next = (beat_cnt_reg == BEAT_MAX) ? beat_cnt_reg : beat_cnt_reg + BEAT_ONE;

`ifdef CONV_MAC_SATURATE_EN
   logic [RES_W:0] wide_sum;
   logic           acc_ovf;
   logic           sat_reg;
   logic           result_sat_reg;

   always_comb begin
      if (SIGNED != 0) begin
         wide_sum = {acc_reg[RES_W-1], acc_reg} + {s2_sum_reg[RES_W-1], s2_sum_reg};
      end else begin
         wide_sum = {1'b0, acc_reg} + {1'b0, s2_sum_reg};
      end
      acc_ovf  = 1'b0;
      acc_next = wide_sum[RES_W-1:0];
      if (SIGNED != 0) begin
         // Signed overflow shows as disagreement between the two top bits.
         if (wide_sum[RES_W] != wide_sum[RES_W-1]) begin
            acc_ovf  = 1'b1;
            acc_next = wide_sum[RES_W] ? {1'b1, {(RES_W-1){1'b0}}} : {1'b0, {(RES_W-1){1'b1}}};
         end
      end else if (wide_sum[RES_W]) begin
         acc_ovf  = 1'b1;
         acc_next = '1;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         sat_reg        <= 1'b0;
         result_sat_reg <= 1'b0;
      end else if (en && s2_valid_reg) begin
         if (s2_last_reg) begin
            result_sat_reg <= sat_reg | acc_ovf;
            sat_reg        <= 1'b0;
         end else begin
            sat_reg <= sat_reg | acc_ovf;
         end
      end
   end

   assign bus.result_sat = result_sat_reg;
`else
   assign acc_next       = acc_reg + s2_sum_reg;
   assign bus.result_sat = 1'b0;
`endif

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < LEN; i++) begin
            s1_prod_reg[i] <= '0;
         end
         s1_valid_reg     <= 1'b0;
         s1_last_reg      <= 1'b0;
         s2_sum_reg       <= '0;
         s2_valid_reg     <= 1'b0;
         s2_last_reg      <= 1'b0;
         acc_reg          <= '0;
         beat_cnt_reg     <= '0;
         result_reg       <= '0;
         result_beats_reg <= '0;
         out_valid_reg    <= 1'b0;
      end else if (en) begin
         s1_valid_reg <= bus.in_valid;
         s1_last_reg  <= bus.in_valid && bus.in_last;
         if (bus.in_valid) begin
            for (int i = 0; i < LEN; i++) begin
               s1_prod_reg[i] <= prod_next[i];
            end
         end

         s2_sum_reg   <= tree_sum;
         s2_valid_reg <= s1_valid_reg;
         s2_last_reg  <= s1_last_reg;

         // A result is either replaced by the next one or retired on this edge.
         out_valid_reg <= 1'b0;
         if (s2_valid_reg) begin
            if (s2_last_reg) begin
               result_reg       <= acc_next;
               result_beats_reg <= beat_next;
               out_valid_reg    <= 1'b1;
               acc_reg          <= '0;
               beat_cnt_reg     <= '0;
            end else begin
               acc_reg      <= acc_next;
               beat_cnt_reg <= beat_next;
            end
         end
      end
   end

   assign bus.result       = result_reg;
   assign bus.result_beats = result_beats_reg;
   assign bus.out_valid    = out_valid_reg;
endmodule

// File: tb/tb_conv_mac_engine.sv
// Scoreboard bench for conv_mac_engine: an unsigned and a signed instance share stimulus;
// a reference model computes packet dot products with plain arithmetic.
module tb_conv_mac_engine;
   localparam int DW = 8;
   localparam int LN = 4;
   localparam int GW = 0;
   localparam int BW = 4;
   localparam int RW = 2 * DW + $clog2(LN) + GW;
   localparam longint U_MAX = (longint'(1) << RW) - 1;
   localparam longint S_MAX = (longint'(1) << (RW - 1)) - 1;
   localparam longint S_MIN = -(longint'(1) << (RW - 1));
   localparam int B_MAX = (1 << BW) - 1;

   typedef struct packed {
      logic [RW-1:0] res;
      logic [BW-1:0] beats;
      logic          sat;
   } exp_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic [LN*DW-1:0] data = '0;
   logic [LN*DW-1:0] kernel = '0;
   logic in_last = 1'b0;
   logic in_valid = 1'b0;
   logic out_ready = 1'b1;
   int rdy_mode = 1;
   int total = 0;
   int bad = 0;
   longint cyc = 0;
   exp_t q_u[$];
   exp_t q_s[$];

   longint u_exact = 0, s_exact = 0, u_clamp = 0, s_clamp = 0;
   bit u_flag = 0, s_flag = 0;
   int beats = 0;
   int ov_cnt = 0;
   longint ov_first = 0, ov_last = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   conv_mac_engine_if #(.DATA_W(DW), .LEN(LN), .GUARD_W(GW), .BEAT_W(BW)) bus_u ();
   conv_mac_engine_if #(.DATA_W(DW), .LEN(LN), .GUARD_W(GW), .BEAT_W(BW)) bus_s ();

   assign bus_u.data = data;
   assign bus_u.kernel = kernel;
   assign bus_u.in_last = in_last;
   assign bus_u.in_valid = in_valid;
   assign bus_u.out_ready = out_ready;
   assign bus_s.data = data;
   assign bus_s.kernel = kernel;
   assign bus_s.in_last = in_last;
   assign bus_s.in_valid = in_valid;
   assign bus_s.out_ready = out_ready;

   conv_mac_engine #(.DATA_W(DW), .LEN(LN), .SIGNED(0), .GUARD_W(GW), .BEAT_W(BW)) u_dut_u (
      .clk(clk), .rst(rst), .bus(bus_u.slave));
   conv_mac_engine #(.DATA_W(DW), .LEN(LN), .SIGNED(1), .GUARD_W(GW), .BEAT_W(BW)) u_dut_s (
      .clk(clk), .rst(rst), .bus(bus_s.slave));

   // Consumer readiness: 0 random, 1 always, 2 never.
   always @(posedge clk) begin
      #1;
      case (rdy_mode)
         1:       out_ready = 1'b1;
         2:       out_ready = 1'b0;
         default: out_ready = ($urandom_range(0, 9) < 7);
      endcase
   end

   task automatic check(input string name, input longint got, input longint exp);
      total++;
      if (got != exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d", name, got, exp);
      end else begin
         $display("ok %s: %0d", name, got);
      end
   endtask

   function automatic void cmp(input string name, input exp_t got, input exp_t e);
      total++;
      if (got !== e) begin
         bad++;
         $display("FAIL %s: got res=%0d beats=%0d sat=%0d expected res=%0d beats=%0d sat=%0d",
                  name, got.res, got.beats, got.sat, e.res, e.beats, e.sat);
      end else begin
         $display("ok %s: res=%0d beats=%0d sat=%0d", name, got.res, got.beats, got.sat);
      end
   endfunction

   function automatic void model_clear();
      u_exact = 0; s_exact = 0; u_clamp = 0; s_clamp = 0;
      u_flag = 0; s_flag = 0; beats = 0;
   endfunction

   // Reference: each beat adds sum(d_i*k_i); a packet reports its total and beat count.
   function automatic void model_accept(input logic [LN*DW-1:0] d, input logic [LN*DW-1:0] k,
                                        input logic last);
      longint ub = 0, sb = 0;
      logic [DW-1:0] a, b;
      exp_t eu, es;
      for (int i = 0; i < LN; i++) begin
         a = d[i*DW +: DW];
         b = k[i*DW +: DW];
         ub += longint'(a) * longint'(b);
         sb += longint'($signed(a)) * longint'($signed(b));
      end
      beats++;
      u_exact += ub;
      s_exact += sb;
      u_clamp += ub;
      if (u_clamp > U_MAX) begin u_clamp = U_MAX; u_flag = 1; end
      s_clamp += sb;
      if (s_clamp > S_MAX) begin s_clamp = S_MAX; s_flag = 1; end
      else if (s_clamp < S_MIN) begin s_clamp = S_MIN; s_flag = 1; end
      if (last) begin
`ifdef CONV_MAC_SATURATE_EN
         eu.res = u_clamp[RW-1:0]; eu.sat = u_flag;
         es.res = s_clamp[RW-1:0]; es.sat = s_flag;
`else
         eu.res = u_exact[RW-1:0]; eu.sat = 1'b0;
         es.res = s_exact[RW-1:0]; es.sat = 1'b0;
`endif
         eu.beats = BW'((beats > B_MAX) ? B_MAX : beats);
         es.beats = eu.beats;
         q_u.push_back(eu);
         q_s.push_back(es);
         model_clear();
      end
   endfunction

   always @(negedge clk) begin
      exp_t got, e;
      if (rst && bus_u.out_valid) begin
         if (ov_cnt == 0) ov_first = cyc;
         ov_last = cyc;
         ov_cnt++;
      end
      if (rst && bus_u.out_valid && out_ready) begin
         got = {bus_u.result, bus_u.result_beats, bus_u.result_sat};
         if (q_u.size() == 0) begin
            total++; bad++;
            $display("FAIL unsigned_unexpected: got res=%0d expected no result", bus_u.result);
         end else begin
            e = q_u.pop_front();
            cmp("unsigned_result", got, e);
         end
      end
      if (rst && bus_s.out_valid && out_ready) begin
         got = {bus_s.result, bus_s.result_beats, bus_s.result_sat};
         if (q_s.size() == 0) begin
            total++; bad++;
            $display("FAIL signed_unexpected: got res=%0d expected no result", bus_s.result);
         end else begin
            e = q_s.pop_front();
            cmp("signed_result", got, e);
         end
      end
   end

   function automatic logic [LN*DW-1:0] fill(input logic [DW-1:0] v);
      return {LN{v}};
   endfunction

   function automatic logic [LN*DW-1:0] rand_vec();
      logic [LN*DW-1:0] v;
      for (int i = 0; i < LN; i++) v[i*DW +: DW] = DW'($urandom_range(0, (1 << DW) - 1));
      return v;
   endfunction

   // Called and returns at posedge+1; waits counts cycles spent with in_ready low.
   task automatic send_beat(input logic [LN*DW-1:0] d, input logic [LN*DW-1:0] k,
                            input logic last, output int waits);
      bit took = 0;
      waits = 0;
      data = d; kernel = k; in_last = last; in_valid = 1'b1;
      while (!took && waits < 300) begin
         @(negedge clk);
         took = bus_u.in_ready;
         @(posedge clk);
         #1;
         if (!took) waits++;
      end
      in_valid = 1'b0;
      in_last = 1'b0;
      if (took) model_accept(d, k, last);
      else check("accept_timeout", waits, 0);
   endtask

   task automatic idle(input int n);
      in_valid = 1'b0;
      repeat (n) begin @(posedge clk); #1; end
   endtask

   task automatic drain();
      int n = 0;
      in_valid = 1'b0;
      rdy_mode = 1;
      while ((q_u.size() != 0 || q_s.size() != 0) && n < 300) begin
         @(posedge clk); #1; n++;
      end
      check("drain_pending", q_u.size() + q_s.size(), 0);
      idle(2);
   endtask

   task automatic check_idle_outputs(input string tag);
      check({tag, "_out_valid"}, bus_u.out_valid, 0);
      check({tag, "_in_ready"}, bus_u.in_ready, 1);
      check({tag, "_result"}, bus_u.result, 0);
      check({tag, "_beats"}, bus_u.result_beats, 0);
      check({tag, "_sat"}, bus_u.result_sat, 0);
      check({tag, "_s_out_valid"}, bus_s.out_valid, 0);
      check({tag, "_s_result"}, bus_s.result, 0);
   endtask

   initial begin
      int w, n, len;
      logic [RW-1:0] held;
      #2 rst = 1'b0;
      #10;
      check_idle_outputs("reset");
      @(posedge clk); #1;
      rst = 1'b1;
      idle(2);

      // Single beat 2x3 over four lanes: 24 after three cycles.
      send_beat(fill(8'd2), fill(8'd3), 1'b1, w);
      n = 1;
      while (!bus_u.out_valid && n < 20) begin @(posedge clk); #1; n++; end
      check("latency_cycles", n, 3);
      check("latency_result", bus_u.result, 24);
      drain();

      for (int i = 0; i < 3; i++) send_beat(fill(8'd1), fill(8'd1), i == 2, w);
      drain();

      // Back-to-back single-beat packets.
      ov_cnt = 0;
      for (int i = 0; i < 10; i++) begin
         send_beat(rand_vec(), rand_vec(), 1'b1, w);
         check("tput_wait", w, 0);
      end
      drain();
      check("tput_results", ov_cnt, 10);
      check("tput_span", ov_last - ov_first, 9);

      // Backpressure: hold a result for five cycles while a beat waits.
      rdy_mode = 2;
      idle(2);
      send_beat(rand_vec(), rand_vec(), 1'b1, w);
      send_beat(rand_vec(), rand_vec(), 1'b0, w);
      send_beat(rand_vec(), rand_vec(), 1'b1, w);
      n = 0;
      while (!bus_u.out_valid && n < 20) begin @(posedge clk); #1; n++; end
      held = bus_u.result;
      fork
         send_beat(rand_vec(), rand_vec(), 1'b1, w);
         begin
            repeat (5) begin
               @(negedge clk);
               check("stall_in_ready", bus_u.in_ready, 0);
               check("stall_result_stable", bus_u.result, held);
            end
            @(posedge clk); #1;
            rdy_mode = 1;
         end
      join
      drain();

      // Overflow / signed corner packets.
      send_beat(fill(8'd255), fill(8'd255), 1'b0, w);
      send_beat(fill(8'd255), fill(8'd255), 1'b1, w);
      send_beat(fill(8'h80), fill(8'h80), 1'b1, w);
      drain();

      // Beat counter saturation.
      for (int i = 0; i < 18; i++) send_beat(fill(8'd1), fill(8'd2), i == 17, w);
      drain();

      // Reset mid-packet discards the partial accumulation.
      send_beat(rand_vec(), rand_vec(), 1'b0, w);
      send_beat(rand_vec(), rand_vec(), 1'b0, w);
      rst = 1'b0;
      model_clear();
      @(negedge clk);
      check_idle_outputs("midrst");
      @(posedge clk); #1;
      rst = 1'b1;
      idle(1);
      send_beat(fill(8'd1), fill(8'd1), 1'b1, w);
      drain();

      // Random traffic with random consumer readiness.
      rdy_mode = 0;
      for (int p = 0; p < 40; p++) begin
         len = $urandom_range(1, 5);
         for (int b = 0; b < len; b++) begin
            send_beat(rand_vec(), rand_vec(), b == len - 1, w);
            if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 2));
         end
      end
      drain();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #500000;
      bad++;
      total++;
      $display("FAIL watchdog: got timeout expected completion");
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
